// File: rtl/wf_play_seq_if.sv
// Waveform RAM read port between the playback
// sequencer (master) and the DPBRAM (slave).
interface wf_play_seq_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] o_ram_addr;
    logic                  o_ram_ce;
    logic [DATA_WIDTH-1:0] i_ram_dout;

    modport master (
        output o_ram_addr,
        output o_ram_ce,
        input  i_ram_dout
    );

    modport slave (
        input  o_ram_addr,
        input  o_ram_ce,
        output i_ram_dout
    );
endinterface

// File: rtl/wf_play_seq.sv
// Waveform playback sequencer: paced RAM reads,
// table repeat, one-cycle sample strobe.
module wf_play_seq #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 16,
    parameter int PERIOD_WIDTH = 16,
    parameter int RAM_LATENCY  = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic                    i_stop,
    input  logic [ADDR_WIDTH:0]     i_length,
    input  logic [PERIOD_WIDTH-1:0] i_period,
    input  logic [15:0]             i_loop_num,
    wf_play_seq_if.master           ram,
    output logic [DATA_WIDTH-1:0]   o_sample,
    output logic                    o_sample_valid,
    output logic [ADDR_WIDTH-1:0]   o_sample_cnt,
    output logic [15:0]             o_loop_cnt,
    output logic                    o_busy,
    output logic                    o_dsp_wf_mode,
    output logic                    o_done,
    output logic                    o_err
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [ADDR_WIDTH:0] LEN_ONE =
        (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] LEN_MAX =
        (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;
    localparam logic [PERIOD_WIDTH-1:0] PER_ONE =
        PERIOD_WIDTH'(1);
    localparam logic [PERIOD_WIDTH-1:0] PER_MIN =
        PERIOD_WIDTH'(RAM_LATENCY + 1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH:0]     len_q, len_d;
    logic [PERIOD_WIDTH-1:0] per_q, per_d;
    logic [15:0]             lnum_q, lnum_d;
    logic [PERIOD_WIDTH-1:0] pcnt_q, pcnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    ce_q, ce_d;
    logic [15:0]             lcnt_q, lcnt_d;
    logic                    err_q, err_d;
    logic                    done_q, done_d;
    logic [DATA_WIDTH-1:0]   smp_q, smp_d;
    logic [ADDR_WIDTH-1:0]   scnt_q, scnt_d;
    logic                    vld_q, vld_d;

    logic [RAM_LATENCY-1:0]  pv_q;
    logic [ADDR_WIDTH-1:0]   pa_q [RAM_LATENCY];

    logic                    stop_act;
    logic                    cfg_ok;
    logic                    last_rd;
    logic                    per_end;
    logic [ADDR_WIDTH-1:0]   nxt_addr;
    logic [ADDR_WIDTH:0]     len_m1;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        per_d    = per_q;
        lnum_d   = lnum_q;
        pcnt_d   = pcnt_q;
        addr_d   = addr_q;
        ce_d     = 1'b0;
        lcnt_d   = lcnt_q;
        err_d    = err_q;
        done_d   = 1'b0;
        smp_d    = smp_q;
        scnt_d   = scnt_q;
        vld_d    = 1'b0;

        stop_act = i_stop && (state_q != IDLE);
        cfg_ok   = (i_length != '0) && (i_length <= LEN_MAX)
                   && (i_period >= PER_MIN);
        len_m1   = len_q - LEN_ONE;
        last_rd  = ce_q && ({1'b0, addr_q} == len_m1);
        per_end  = (pcnt_q == per_q - PER_ONE);
        nxt_addr = ({1'b0, addr_q} == len_m1) ? '0
                   : addr_q + ADDR_WIDTH'(1);

        unique case (state_q)
            IDLE: begin
                if (i_start && !i_stop) begin
                    if (cfg_ok) begin
                        len_d   = i_length;
                        per_d   = i_period;
                        lnum_d  = i_loop_num;
                        err_d   = 1'b0;
                        pcnt_d  = '0;
                        addr_d  = '0;
                        ce_d    = 1'b1;
                        // a one-entry table completes a pass on its first read
                        lcnt_d  = (i_length == LEN_ONE) ? 16'd1 : 16'd0;
                        state_d = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                pcnt_d = per_end ? '0 : pcnt_q + PER_ONE;
                if (i_stop) begin
                    state_d = IDLE;
                end else if (last_rd && (lnum_q != '0)
                             && (lcnt_q == lnum_q)) begin
                    state_d = DRAIN;
                end else if (per_end) begin
                    ce_d   = 1'b1;
                    addr_d = nxt_addr;
                    if ({1'b0, nxt_addr} == len_m1)
                        lcnt_d = lcnt_q + 16'd1;
                end
            end
            DRAIN: begin
                if (i_stop) begin
                    state_d = IDLE;
                end else if (vld_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pv_q[RAM_LATENCY-1] && !stop_act) begin
            vld_d  = 1'b1;
            smp_d  = ram.i_ram_dout;
            scnt_d = pa_q[RAM_LATENCY-1];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            per_q   <= '0;
            lnum_q  <= '0;
            pcnt_q  <= '0;
            addr_q  <= '0;
            ce_q    <= 1'b0;
            lcnt_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            smp_q   <= '0;
            scnt_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            per_q   <= per_d;
            lnum_q  <= lnum_d;
            pcnt_q  <= pcnt_d;
            addr_q  <= addr_d;
            ce_q    <= ce_d;
            lcnt_q  <= lcnt_d;
            err_q   <= err_d;
            done_q  <= done_d;
            smp_q   <= smp_d;
            scnt_q  <= scnt_d;
            vld_q   <= vld_d;
        end
    end

    // Read-tag pipeline matching RAM latency; flushed on abort.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            pv_q <= '0;
            for (int i = 0; i < RAM_LATENCY; i++)
                pa_q[i] <= '0;
        end else if (stop_act) begin
            pv_q <= '0;
        end else begin
            pv_q[0] <= ce_q;
            pa_q[0] <= addr_q;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                pv_q[i] <= pv_q[i-1];
                pa_q[i] <= pa_q[i-1];
            end
        end
    end

    assign ram.o_ram_addr   = addr_q;
    assign ram.o_ram_ce     = ce_q;
    assign o_sample         = smp_q;
    assign o_sample_valid   = vld_q;
    assign o_sample_cnt     = scnt_q;
    assign o_loop_cnt       = lcnt_q;
    assign o_busy           = (state_q != IDLE);
    assign o_dsp_wf_mode    = (state_q != IDLE);
    assign o_done           = done_q;
    assign o_err            = err_q;
endmodule
